// File: rtl/rca_pipe_addsub_if.sv
// Handshake and operand/result bundle for the pipelined ripple-carry adder/subtractor.
// The master drives operands and out_ready; the slave (adder) drives in_ready and results.
interface rca_pipe_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH-bit chain split into STAGES registered segments.
// Optional RCA_PIPE_SAT_EN: clamp the result to the signed range on overflow in the last stage.
module rca_pipe_addsub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input logic               clk,
  input logic               rst_n,
  rca_pipe_addsub_if.slave  bus
);

  localparam int unsigned SEG = WIDTH / STAGES;
  localparam int unsigned SW  = SEG + 1;

  if (WIDTH < 2) begin : g_chk_width
    $error("rca_pipe_addsub: WIDTH must be >= 2");
  end
  if ((STAGES == 0) || ((WIDTH % STAGES) != 0)) begin : g_chk_stages
    $error("rca_pipe_addsub: WIDTH must be a multiple of STAGES");
  end

  // Stage k resolves bits [LO +: SEG]; operand bits above are forwarded, resolved sum bits below.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned LO = k * SEG;
    localparam int unsigned HI = LO + SEG;

    logic             v_in;
    logic             c_in;
    logic [WIDTH-1:LO] a_in;
    logic [WIDTH-1:LO] b_in;
    logic [SEG:0]     seg;
    logic [HI-1:0]    s_nx;
    logic [HI-1:0]    s_fin;
    logic             en;
    logic             en_dn;
    logic             ld;
    logic             v_q;
    logic             c_q;
    logic [HI-1:0]    s_q;

    if (k == 0) begin : g_src
      assign v_in = bus.in_valid;
      assign c_in = bus.sub ^ bus.cin;
      assign a_in = bus.a;
      assign b_in = bus.sub ? ~bus.b : bus.b;
      assign s_nx = seg[SEG-1:0];
    end else begin : g_src
      assign v_in = g_st[k-1].v_q;
      assign c_in = g_st[k-1].c_q;
      assign a_in = g_st[k-1].g_fwd.a_q;
      assign b_in = g_st[k-1].g_fwd.b_q;
      assign s_nx = {seg[SEG-1:0], g_st[k-1].s_q};
    end

    assign seg = SW'(a_in[HI-1:LO]) + SW'(b_in[HI-1:LO]) + SW'(c_in);

    // Ready chain: a stage may load if it is empty or its successor is loading.
    if (k == STAGES - 1) begin : g_dn
      assign en_dn = bus.out_ready;
    end else begin : g_dn
      assign en_dn = g_st[k+1].en;
    end
    assign en = ~v_q | en_dn;
    assign ld = en & v_in;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        if (en) v_q <= v_in;
        if (ld) begin
          c_q <= seg[SEG];
          s_q <= s_fin;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;

      assign s_fin = s_nx;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld) begin
          a_q <= a_in[WIDTH-1:HI];
          b_q <= b_in[WIDTH-1:HI];
        end
      end
    end else begin : g_last
      logic c_msb;
      logic ovf_nx;
      logic ovf_q;

      // Carry into the MSB recovered from the MSB sum bit.
      assign c_msb  = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ seg[SEG-1];
      assign ovf_nx = c_msb ^ seg[SEG];

`ifdef RCA_PIPE_SAT_EN
      // Both operands share a sign on overflow, so a's sign picks the clamp direction.
      assign s_fin = !ovf_nx ? s_nx :
                     (a_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
      assign s_fin = s_nx;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (ld) begin
          ovf_q <= ovf_nx;
        end
      end
    end
  end

  assign bus.in_ready  = g_st[0].en;
  assign bus.out_valid = g_st[STAGES-1].v_q;
  assign bus.sum       = g_st[STAGES-1].s_q;
  assign bus.cout      = g_st[STAGES-1].c_q;
  assign bus.ovf       = g_st[STAGES-1].g_last.ovf_q;

  // A stalled result must stay put until it is taken.
  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.sum) && $stable(bus.cout) && $stable(bus.ovf)));

  a_full_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
    (!bus.in_ready) |-> (bus.out_valid && !bus.out_ready));

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Directed and randomised checks of rca_pipe_addsub (WIDTH=16; STAGES 4, plus 1 and 16 in the random run).
module tb_rca_pipe_addsub;

  localparam int unsigned W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rst_r = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rca_pipe_addsub_if #(.WIDTH(W)) bus ();
  rca_pipe_addsub #(.WIDTH(W), .STAGES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {cout, ovf, sum}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic cin);
    logic [15:0] bx;
    logic        ci;
    logic [16:0] full;
    logic        ov;
    logic [15:0] s;
    bx   = sub ? ~b : b;
    ci   = sub ^ cin;
    full = 17'(a) + 17'(bx) + 17'(ci);
    ov   = (a[15] == bx[15]) && (full[15] != a[15]);
    s    = full[15:0];
`ifdef RCA_PIPE_SAT_EN
    if (ov) s = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {full[16], ov, s};
  endfunction

  task automatic send_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic cin,
                            input logic [15:0] e_sum, input logic e_cout, input logic e_ovf);
    int lat;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = sub; bus.cin = cin;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    check_eq({tag, "_latency"}, lat, 4);
    check_eq({tag, "_sum"}, 32'(bus.sum), 32'(e_sum));
    check_eq({tag, "_cout"}, 32'(bus.cout), 32'(e_cout));
    check_eq({tag, "_ovf"}, 32'(bus.ovf), 32'(e_ovf));
  endtask

  task automatic test_stall();
    logic [17:0] q[$];
    int sent = 0, popd = 0, stall_left = 6, stalled = 0, extra = 0;
    for (int cyc = 0; cyc < 80 && popd < 8; cyc++) begin
      @(negedge clk);
      bus.in_valid  = (sent < 8);
      bus.a         = 16'h1111 * 16'(sent + 1);
      bus.b         = 16'h0F0F ^ 16'(sent);
      bus.sub       = 1'(sent);
      bus.cin       = 1'(sent >> 1);
      bus.out_ready = !((popd == 1) && (stall_left > 0));
      if (!bus.out_ready) stall_left--;
      #1;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check_eq("t4_spurious_valid", 32'(bus.out_valid), 0);
        end else if (bus.out_ready) begin
          check_eq("t4_result", {14'b0, bus.cout, bus.ovf, bus.sum}, 32'(q[0]));
          void'(q.pop_front());
          popd++;
        end else begin
          check_eq("t4_held", {14'b0, bus.cout, bus.ovf, bus.sum}, 32'(q[0]));
          check_eq("t4_in_ready_full", 32'(bus.in_ready), 0);
          stalled++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.a, bus.b, bus.sub, bus.cin));
        sent++;
      end
    end
    check_eq("t4_count", popd, 8);
    check_eq("t4_stall_cycles", stalled, 6);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) extra++;
    end
    check_eq("t4_no_duplicate", extra, 0);
  endtask

  task automatic test_reset_flight();
    int stale = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 16'h1234 + 16'(i); bus.b = 16'h1111; bus.sub = 1'b0; bus.cin = 1'b0;
      #1;
      check_eq("t5_in_ready", 32'(bus.in_ready), 1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("t5_pre_valid", 32'(bus.out_valid), 1);
    check_eq("t5_pre_sum", 32'(bus.sum), 32'h2345);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(bus.out_valid), 0);
    check_eq("t5_rst_sum", 32'(bus.sum), 0);
    check_eq("t5_rst_cout", 32'(bus.cout), 0);
    check_eq("t5_rst_ovf", 32'(bus.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check_eq("t5_post_in_ready", 32'(bus.in_ready), 1);
    repeat (8) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    check_eq("t5_no_stale", stale, 0);
  endtask

  // Random traffic against the model on three pipeline depths.
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int unsigned S = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    rca_pipe_addsub_if #(.WIDTH(W)) rif ();
    rca_pipe_addsub #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .rst_n(rst_r), .bus(rif.slave));
    bit done = 1'b0;

    initial begin : p_rnd
      logic [17:0] q[$];
      logic [18:0] held;
      bit          stall_prev;
      int          acc;
      int          popd;
      acc = 0; popd = 0; stall_prev = 1'b0; held = '0;
      rif.in_valid = 1'b0; rif.a = '0; rif.b = '0; rif.sub = 1'b0; rif.cin = 1'b0;
      rif.out_ready = 1'b0;
      wait (rst_r == 1'b0);
      wait (rst_r == 1'b1);
      for (int cyc = 0; cyc < 20000 && popd < 1000; cyc++) begin
        @(negedge clk);
        rif.in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
        rif.a         = 16'($urandom);
        rif.b         = 16'($urandom);
        rif.sub       = 1'($urandom);
        rif.cin       = 1'($urandom);
        rif.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (stall_prev)
          check_eq($sformatf("rnd_s%0d_hold", S),
                   {13'b0, rif.out_valid, rif.cout, rif.ovf, rif.sum}, 32'(held));
        stall_prev = rif.out_valid && !rif.out_ready;
        held       = {rif.out_valid, rif.cout, rif.ovf, rif.sum};
        if (rif.out_valid && rif.out_ready) begin
          if (q.size() == 0) begin
            check_eq($sformatf("rnd_s%0d_spurious", S), 32'(rif.out_valid), 0);
          end else begin
            check_eq($sformatf("rnd_s%0d_result", S),
                     {14'b0, rif.cout, rif.ovf, rif.sum}, 32'(q[0]));
            void'(q.pop_front());
            popd++;
          end
        end
        if (rif.in_valid && rif.in_ready) begin
          q.push_back(model(rif.a, rif.b, rif.sub, rif.cin));
          acc++;
        end
      end
      check_eq($sformatf("rnd_s%0d_count", S), popd, 1000);
      done = 1'b1;
    end
  end

  initial begin : p_main
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    rst_r = 1'b0;
    #2;
    check_eq("reset_out_valid", 32'(bus.out_valid), 0);
    check_eq("reset_sum", 32'(bus.sum), 0);
    check_eq("reset_cout", 32'(bus.cout), 0);
    check_eq("reset_ovf", 32'(bus.ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rst_r = 1'b1;
    #1;
    check_eq("reset_in_ready", 32'(bus.in_ready), 1);

    send_check("t1_ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef RCA_PIPE_SAT_EN
    send_check("t2_pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
`else
    send_check("t2_pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
    send_check("t3_5m7", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
`ifdef RCA_PIPE_SAT_EN
    send_check("t3_neg_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1);
`else
    send_check("t3_neg_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`endif
    send_check("t3_borrow_in", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
    send_check("t3_zero", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);

    test_stall();
    test_reset_flight();

    for (int i = 0; i < 30000; i++) begin
      if (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done) break;
      @(posedge clk);
    end
    check_eq("rnd_done", 32'({g_rnd[0].done, g_rnd[1].done, g_rnd[2].done}), 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
